// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the req/ack handshake to instruction memory,
// and applies hazard freezes and taken-branch redirects before feeding the IF/ID register.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_hold_buf;
    logic [31:0] r_disc_addr;
    logic [31:0] r_pc_out;
    logic [31:0] r_instr_out;
    logic        r_instr_valid;
    logic [31:0] w_pc_next;

    assign w_pc_next = r_pc + PC_INC;

    // Request/address are valid/ready style: once imem_req=1 with imem_addr=A, A is held
    // until the cycle imem_ack=1. A squashed request keeps its address via r_disc_addr.
    assign imem_req    = rst && (r_state != S_HOLD);
    assign imem_addr   = (r_state == S_DISCARD) ? r_disc_addr : r_pc;
    assign pc_out      = r_pc_out;
    assign instr_out   = r_instr_out;
    assign instr_valid = r_instr_valid;
    assign dbg_state   = r_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_FETCH;
            r_pc          <= RESET_PC;
            r_hold_buf    <= 32'h0;
            r_disc_addr   <= 32'h0;
            r_pc_out      <= 32'h0;
            r_instr_out   <= 32'h0;
            r_instr_valid <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (branch_taken) begin
                        r_pc          <= branch_addr;
                        r_pc_out      <= 32'h0;
                        r_instr_out   <= 32'h0;
                        r_instr_valid <= 1'b0;
                        if (!imem_ack) begin
                            r_disc_addr <= r_pc;
                            r_state     <= S_DISCARD;
                        end
                    end else if (freeze) begin
                        if (imem_ack) begin
                            r_hold_buf <= imem_rdata;
                            r_state    <= S_HOLD;
                        end
                    end else if (imem_ack) begin
                        r_instr_out   <= imem_rdata;
                        r_pc_out      <= w_pc_next;
                        r_instr_valid <= 1'b1;
                        r_pc          <= w_pc_next;
                    end else begin
                        r_pc_out      <= 32'h0;
                        r_instr_out   <= 32'h0;
                        r_instr_valid <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (branch_taken) begin
                        r_pc          <= branch_addr;
                        r_hold_buf    <= 32'h0;
                        r_pc_out      <= 32'h0;
                        r_instr_out   <= 32'h0;
                        r_instr_valid <= 1'b0;
                        r_state       <= S_FETCH;
                    end else if (!freeze) begin
                        r_instr_out   <= r_hold_buf;
                        r_pc_out      <= w_pc_next;
                        r_instr_valid <= 1'b1;
                        r_pc          <= w_pc_next;
                        r_state       <= S_FETCH;
                    end
                end
                S_DISCARD: begin
                    // The squashed request still has to complete; its data is thrown away.
                    if (branch_taken) r_pc <= branch_addr;
                    r_pc_out      <= 32'h0;
                    r_instr_out   <= 32'h0;
                    r_instr_valid <= 1'b0;
                    if (imem_ack) r_state <= S_FETCH;
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

endmodule
